// File: rtl/cdb_pkg.sv
// Shared types and default sizes for the common data bus producer.
package cdb_pkg;
   localparam int DEF_NUM_FU     = 4;
   localparam int DEF_FIFO_DEPTH = 2;
   localparam int PD_BITS        = 6;
   localparam int ROB_BITS       = 5;
   localparam int XLEN           = 32;

   typedef struct packed {
      logic [PD_BITS-1:0]  pd;
      logic [4:0]          rd;
      logic [XLEN-1:0]     data;
      logic [ROB_BITS-1:0] rob;
   } cdb_pkt_t;

   // (a + b) mod n for a, b < n, without a divider
   function automatic int wrap_add(int a, int b, int n);
      int s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction
endpackage

// File: rtl/cdb_if.sv
// FU completion ports plus CDB broadcast bundle; master = arbiter side, slave = FU/consumer side.
interface cdb_if import cdb_pkg::*; #(parameter int NFU = DEF_NUM_FU) ();
   logic                      flush;
   logic [NFU-1:0]            fu_valid;
   logic [NFU-1:0]            fu_ready;
   cdb_pkt_t [NFU-1:0]        fu_pkt;
   logic                      cdb_valid;
   logic [PD_BITS-1:0]        cdb_pd;
   logic [4:0]                cdb_rd;
   logic [XLEN-1:0]           cdb_data;
   logic [ROB_BITS-1:0]       cdb_rob;
   logic                      regf_we;

   modport master (
      input  flush, fu_valid, fu_pkt,
      output fu_ready, cdb_valid, cdb_pd, cdb_rd, cdb_data, cdb_rob, regf_we
   );

   modport slave (
      output flush, fu_valid, fu_pkt,
      input  fu_ready, cdb_valid, cdb_pd, cdb_rd, cdb_data, cdb_rob, regf_we
   );
endinterface

// File: rtl/cdb_fu_fifo.sv
// Per-FU completion queue: synchronous FIFO of cdb_pkt_t with flush.
module cdb_fu_fifo import cdb_pkg::*; #(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  logic     push,
   input  logic     pop,
   input  cdb_pkt_t din,
   output logic     full,
   output logic     empty,
   output cdb_pkt_t head
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   cdb_pkt_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // full comes from the registered count only, so a dequeue never frees a slot same-cycle
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU queues, round-robin select, registered broadcast.
// Optional CDB_PERF_CNT_EN adds saturating broadcast/stall counters.
module cdb_arbiter import cdb_pkg::*; #(
   parameter int NUM_FU     = DEF_NUM_FU,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   cdb_if.master       bus
`ifdef CDB_PERF_CNT_EN
   ,
   output logic [31:0] perf_bcast_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);
   localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] full;
   logic [NUM_FU-1:0] empty;
   logic [NUM_FU-1:0] pop;
   cdb_pkt_t          head [NUM_FU];
   logic [RR_W-1:0]   rr_ptr;
   logic [RR_W-1:0]   rr_nxt;
   logic [RR_W-1:0]   cand;
   logic [RR_W-1:0]   win;
   logic              win_vld;
   logic              cdb_valid_q;
   cdb_pkt_t          out_q;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (bus.flush),
         .push  (bus.fu_valid[i]),
         .pop   (pop[i]),
         .din   (bus.fu_pkt[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end

   assign bus.fu_ready = ~full;

   // first non-empty queue at or after rr_ptr
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = RR_W'(wrap_add(int'(rr_ptr), k, NUM_FU));
         if (!win_vld && !empty[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (win_vld) pop[win] = 1'b1;
   end

   assign rr_nxt = (win == RR_W'(NUM_FU - 1)) ? '0 : win + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid_q <= 1'b0;
         out_q       <= '0;
         rr_ptr      <= '0;
      end else if (bus.flush) begin
         cdb_valid_q <= 1'b0;
         rr_ptr      <= '0;
      end else if (win_vld) begin
         cdb_valid_q <= 1'b1;
         out_q       <= head[win];
         rr_ptr      <= rr_nxt;
      end else begin
         cdb_valid_q <= 1'b0;
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_pd    = out_q.pd;
   assign bus.cdb_rd    = out_q.rd;
   assign bus.cdb_data  = out_q.data;
   assign bus.cdb_rob   = out_q.rob;
   assign bus.regf_we   = cdb_valid_q && (out_q.rd != 5'd0);

`ifdef CDB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_bcast_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (cdb_valid_q && (perf_bcast_cnt != '1))
            perf_bcast_cnt <= perf_bcast_cnt + 1'b1;
         if ((|(bus.fu_valid & full)) && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue expected broadcasts, a negedge monitor checks them.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cdb_if bus ();

`ifdef CDB_PERF_CNT_EN
   logic [31:0] perf_bcast_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   cdb_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef CDB_PERF_CNT_EN
      ,
      .perf_bcast_cnt (perf_bcast_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int       checks = 0;
   int       errors = 0;
   cdb_pkt_t sb [$];
   logic     sb_we [$];
   cdb_pkt_t mon_e;
   logic     mon_w;
   cdb_pkt_t a_pk [4];
   cdb_pkt_t b_pk [3];
   logic [3:0] rdy;
   int       ia, ib;
   bit       saw_full1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic cdb_pkt_t mk(int pd, int rd, logic [31:0] data, int rob);
      cdb_pkt_t p;
      p.pd   = PD_BITS'(pd);
      p.rd   = 5'(rd);
      p.data = data;
      p.rob  = ROB_BITS'(rob);
      return p;
   endfunction

   function automatic void exp_push(cdb_pkt_t p, logic we);
      sb.push_back(p);
      sb_we.push_back(we);
   endfunction

   task automatic fire(logic [3:0] mask);
      bus.fu_valid = mask;
      @(posedge clk);
      #1;
      bus.fu_valid = '0;
   endtask

   task automatic drain(string name, int max);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk(name, 64'(sb.size()), 64'd0);
      sb.delete();
      sb_we.delete();
   endtask

   always @(negedge clk) begin
      if (rst && bus.cdb_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bcast actual pd=%0d expected no broadcast t=%0t", bus.cdb_pd, $time);
         end else begin
            mon_e = sb.pop_front();
            mon_w = sb_we.pop_front();
            chk("bcast_pkt", 64'({bus.cdb_pd, bus.cdb_rd, bus.cdb_data, bus.cdb_rob}), 64'(mon_e));
            chk("bcast_we", 64'(bus.regf_we), 64'(mon_w));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      bus.flush    = 1'b0;
      bus.fu_valid = '0;
      bus.fu_pkt   = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_ready", 64'(bus.fu_ready), 64'hF);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // idle after reset release
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("idle_ready", 64'(bus.fu_ready), 64'hF);
         chk("idle_valid", 64'(bus.cdb_valid), 64'd0);
         chk("idle_we", 64'(bus.regf_we), 64'd0);
      end

      // all four FUs together from rr_ptr=0, then FU3+FU0 -> FU0 first
      for (int i = 0; i < 4; i++) begin
         bus.fu_pkt[i] = mk(10 + i, 1 + i, 32'h1000_0000 + i, 4 + i);
         exp_push(mk(10 + i, 1 + i, 32'h1000_0000 + i, 4 + i), 1'b1);
      end
      fire(4'b1111);
      drain("drain_all4", 10);
      bus.fu_pkt[3] = mk(23, 7, 32'h2323_2323, 9);
      bus.fu_pkt[0] = mk(20, 6, 32'h2020_2020, 8);
      exp_push(mk(20, 6, 32'h2020_2020, 8), 1'b1);
      exp_push(mk(23, 7, 32'h2323_2323, 9), 1'b1);
      fire(4'b1001);
      drain("drain_fu3_fu0", 10);

      // single result, one-cycle latency, then idle
      bus.fu_pkt[0] = mk(45, 2, 32'hDEAD_BEEF, 3);
      exp_push(mk(45, 2, 32'hDEAD_BEEF, 3), 1'b1);
      fire(4'b0001);
      @(posedge clk);
      #1;
      chk("lat_valid", 64'(bus.cdb_valid), 64'd1);
      chk("lat_pd", 64'(bus.cdb_pd), 64'd45);
      chk("lat_rob", 64'(bus.cdb_rob), 64'd3);
      chk("lat_we", 64'(bus.regf_we), 64'd1);
      @(posedge clk);
      #1;
      chk("lat_after_valid", 64'(bus.cdb_valid), 64'd0);
      drain("drain_single", 4);

      // FU0 streaming vs FU1 pushing 3 (rr_ptr=1): FU1 queue fills, order preserved
      for (int i = 0; i < 4; i++) a_pk[i] = mk(1 + i, 3, 32'hA000_0000 + i, i);
      for (int i = 0; i < 3; i++) b_pk[i] = mk(8 + i, 4, 32'hB000_0000 + i, 16 + i);
      exp_push(b_pk[0], 1'b1);
      exp_push(a_pk[0], 1'b1);
      exp_push(b_pk[1], 1'b1);
      exp_push(a_pk[1], 1'b1);
      exp_push(b_pk[2], 1'b1);
      exp_push(a_pk[2], 1'b1);
      exp_push(a_pk[3], 1'b1);
      ia = 0;
      ib = 0;
      saw_full1 = 1'b0;
      for (int cyc = 0; cyc < 20 && (ia < 4 || ib < 3); cyc++) begin
         bus.fu_valid = {2'b00, ib < 3, ia < 4};
         if (ia < 4) bus.fu_pkt[0] = a_pk[ia];
         if (ib < 3) bus.fu_pkt[1] = b_pk[ib];
         rdy = bus.fu_ready;
         if (!rdy[1]) saw_full1 = 1'b1;
         @(posedge clk);
         #1;
         if (bus.fu_valid[0] && rdy[0]) ia++;
         if (bus.fu_valid[1] && rdy[1]) ib++;
      end
      bus.fu_valid = '0;
      chk("stream_full1_seen", 64'(saw_full1), 64'd1);
      chk("stream_a_sent", 64'(ia), 64'd4);
      chk("stream_b_sent", 64'(ib), 64'd3);
      drain("drain_stream", 12);

      // rd=0 result: broadcast without regfile write
      bus.fu_pkt[2] = mk(33, 0, 32'h0000_3333, 11);
      exp_push(mk(33, 0, 32'h0000_3333, 11), 1'b0);
      fire(4'b0100);
      drain("drain_rd0", 4);

      // FU2 queues two; first broadcasts, flush squashes the second and a same-cycle FU0 push
      bus.fu_pkt[2] = mk(40, 5, 32'h4040_4040, 12);
      exp_push(mk(40, 5, 32'h4040_4040, 12), 1'b1);
      fire(4'b0100);
      bus.fu_pkt[2] = mk(41, 5, 32'h4141_4141, 13);
      fire(4'b0100);
      bus.fu_pkt[0] = mk(42, 5, 32'h4242_4242, 14);
      bus.flush = 1'b1;
      fire(4'b0001);
      bus.flush = 1'b0;
      chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
      chk("flush_ready", 64'(bus.fu_ready), 64'hF);
      repeat (4) @(posedge clk);
      #1;
      chk("flush_quiet", 64'(bus.cdb_valid), 64'd0);
      // rr_ptr must be back at 0: FU1 before FU3
      bus.fu_pkt[1] = mk(50, 9, 32'h5050_5050, 20);
      bus.fu_pkt[3] = mk(51, 9, 32'h5151_5151, 21);
      exp_push(mk(50, 9, 32'h5050_5050, 20), 1'b1);
      exp_push(mk(51, 9, 32'h5151_5151, 21), 1'b1);
      fire(4'b1010);
      drain("drain_after_flush", 6);

      // async reset mid-stream: first broadcast (FU0) seen, rest discarded
      for (int i = 0; i < 4; i++) bus.fu_pkt[i] = mk(60 + i, 2, 32'h6000_0000 + i, 24 + i);
      exp_push(mk(60, 2, 32'h6000_0000, 24), 1'b1);
      fire(4'b1111);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_mid_we", 64'(bus.regf_we), 64'd0);
      chk("rst_mid_sb", 64'(sb.size()), 64'd0);
      sb.delete();
      sb_we.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_ready", 64'(bus.fu_ready), 64'hF);
         chk("post_rst_valid", 64'(bus.cdb_valid), 64'd0);
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
